mem_port_arbiter: RTL and testbench

- Shares the single 256-bit Data_Memory port between two cache-side requesters: port 0 is the D-cache and port 1 is the I-cache or refill engine.
- Sits between the cache controllers and Data_Memory and uses the same enable/write/ack handshake on both sides.
- Owns the transaction from grant to ack, forces a one-cycle enable-low gap between transactions, and flags hung transactions with a watchdog.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 21 ++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the Data_Memory port arbiter.
// State encoding, default widths and the watchdog width helper.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 256;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout);
    endfunction

    function automatic logic is_grant(input arb_state_t s);
        return (s == GRANT0) || (s == GRANT1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin select.
// On a tie the port that was not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single Data_Memory line port between D-cache (port 0)
// and I-cache/refill (port 1) with a release gap and a watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic              owner_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic              mem_enable_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;

    logic              grant_valid;
    logic              grant_idx;
    logic              in_grant;
    logic              grant_start;
    logic              wdog_hit;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_pick2 u_pick (
        .req         ({m1_enable_i, m0_enable_i}),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign in_grant    = is_grant(state_q);
    assign grant_start = !in_grant && grant_valid;
    assign wdog_hit    = in_grant && !mem_ack_i && (cnt_q == CNT_MAX);

    assign sel_write = grant_idx ? m1_write_i : m0_write_i;
    assign sel_addr  = grant_idx ? m1_addr_i  : m0_addr_i;
    assign sel_data  = grant_idx ? m1_data_i  : m0_data_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RELEASE: begin
                if (grant_valid)
                    state_d = grant_idx ? GRANT1 : GRANT0;
                else
                    state_d = IDLE;
            end
            GRANT0, GRANT1: begin
                if (mem_ack_i || wdog_hit)
                    state_d = RELEASE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= is_grant(state_d);
            if (grant_start) begin
                last_q      <= grant_idx;
                cnt_q       <= '0;
                mem_write_q <= sel_write;
                mem_addr_q  <= sel_addr;
                mem_data_q  <= sel_data;
            end else if (in_grant && !mem_ack_i && !wdog_hit) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Sticky until reset so software can see a past hang
            if (wdog_hit)
                err_q <= 1'b1;
        end
    end

    assign m0_ack_o  = (state_q == GRANT0) && mem_ack_i;
    assign m1_ack_o  = (state_q == GRANT1) && mem_ack_i;
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    assign owner_o = (state_q == GRANT1);
    assign busy_o  = in_grant;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Second instance with a short watchdog covers the abort path.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;
    localparam logic [DW-1:0] LINE0 =
        256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;
    localparam logic [DW-1:0] WD0 = {8{32'hA5A5_0020}};
    localparam logic [DW-1:0] WD2 = {8{32'h5A5A_0040}};
    localparam logic [DW-1:0] RD1 = {8{32'h1234_5678}};
    localparam logic [DW-1:0] RD2 = {8{32'hCAFE_0400}};
    localparam logic [DW-1:0] RD3 = {8{32'hBEEF_0C00}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          rst_wd = 1'b1;
    logic          m0_en = 1'b0, m0_we = 1'b0;
    logic          m1_en = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          mem_ack = 1'b0, mem_ack_wd = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          m0_ack, m1_ack, mem_en, mem_we, owner, busy, err;
    logic [DW-1:0] m0_data, m1_data, mem_wd;
    logic [AW-1:0] mem_addr;

    logic          w_m0_ack, w_m1_ack, w_en, w_we, w_owner, w_busy, w_err;
    logic [DW-1:0] w_m0_data, w_m1_data, w_wd;
    logic [AW-1:0] w_addr;

    int n_asserts = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_enable_i(m0_en), .m0_write_i(m0_we),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m0_ack_o(m0_ack), .m0_data_o(m0_data),
        .m1_enable_i(m1_en), .m1_write_i(m1_we),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m1_ack_o(m1_ack), .m1_data_o(m1_data),
        .mem_enable_o(mem_en), .mem_write_o(mem_we),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wd),
        .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
        .owner_o(owner), .busy_o(busy), .err_o(err)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut_wd (
        .clk_i(clk), .rst_i(rst_wd),
        .m0_enable_i(m0_en), .m0_write_i(m0_we),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
        .m0_ack_o(w_m0_ack), .m0_data_o(w_m0_data),
        .m1_enable_i(m1_en), .m1_write_i(m1_we),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
        .m1_ack_o(w_m1_ack), .m1_data_o(w_m1_data),
        .mem_enable_o(w_en), .mem_write_o(w_we),
        .mem_addr_o(w_addr), .mem_data_o(w_wd),
        .mem_ack_i(mem_ack_wd), .mem_data_i(mem_rdata),
        .owner_o(w_owner), .busy_o(w_busy), .err_o(w_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk1("rst_en", mem_en, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_ack0", m0_ack, 1'b0);
        chk1("rst_ack1", m1_ack, 1'b0);
        chkw("rst_addr", DW'(mem_addr), '0);
        chkw("rst_wdata", mem_wd, '0);
        rst = 1'b0;
        tick();

        // single port-0 read, 10-cycle memory latency
        m0_en = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000;
        #1;
        chk1("t1_en_pre", mem_en, 1'b0);
        tick();
        chk1("t1_en", mem_en, 1'b1);
        chk1("t1_owner", owner, 1'b0);
        chk1("t1_busy", busy, 1'b1);
        chkw("t1_addr", DW'(mem_addr), '0);
        for (int i = 1; i <= 9; i++) begin
            chk1("t1_noack", m0_ack, 1'b0);
            tick();
        end
        mem_rdata = LINE0; mem_ack = 1'b1;
        #1;
        chk1("t1_ack", m0_ack, 1'b1);
        chkw("t1_data", m0_data, LINE0);
        chk1("t1_ack1", m1_ack, 1'b0);
        tick();
        mem_ack = 1'b0; m0_en = 1'b0;
        #1;
        chk1("t1_gap", mem_en, 1'b0);
        chk1("t1_pulse", m0_ack, 1'b0);
        chk1("t1_rel_busy", busy, 1'b0);
        tick();
        chk1("t1_idle", mem_en, 1'b0);

        // simultaneous requests after reset
        rst = 1'b1; tick(); rst = 1'b0; tick();
        m0_en = 1'b1; m0_we = 1'b1; m0_addr = 32'h0020; m0_wdata = WD0;
        m1_en = 1'b1; m1_we = 1'b0; m1_addr = 32'h0400; m1_wdata = '0;
        tick();
        chk1("t2_owner0", owner, 1'b0);
        chkw("t2_addr0", DW'(mem_addr), DW'(32'h0020));
        chk1("t2_we0", mem_we, 1'b1);
        chkw("t2_wdata0", mem_wd, WD0);
        mem_ack = 1'b1; mem_rdata = RD1;
        #1;
        chk1("t2_ack0", m0_ack, 1'b1);
        chk1("t2_ack1_lo", m1_ack, 1'b0);
        tick();
        mem_ack = 1'b0; m0_en = 1'b0;
        #1;
        chk1("t2_gap", mem_en, 1'b0);
        chk1("t2_gap_busy", busy, 1'b0);
        tick();
        chk1("t2_en1", mem_en, 1'b1);
        chk1("t2_owner1", owner, 1'b1);
        chkw("t2_addr1", DW'(mem_addr), DW'(32'h0400));
        chk1("t2_we1", mem_we, 1'b0);
        mem_ack = 1'b1; mem_rdata = RD2;
        #1;
        chk1("t2_ack1", m1_ack, 1'b1);
        chkw("t2_data1", m1_data, RD2);
        chk1("t2_ack0_lo", m0_ack, 1'b0);
        tick();
        mem_ack = 1'b0; m1_en = 1'b0;
        tick();
        m0_en = 1'b1; m1_en = 1'b1;
        tick();
        chk1("t2_tie_owner", owner, 1'b0);
        chkw("t2_tie_addr", DW'(mem_addr), DW'(32'h0020));
        mem_ack = 1'b1;
        #1;
        chk1("t2_tie_ack", m0_ack, 1'b1);
        tick();
        mem_ack = 1'b0; m0_en = 1'b0; m1_en = 1'b0;
        tick();

        // write-back then refill on port 0, port 1 always requesting
        rst = 1'b1; tick(); rst = 1'b0;
        m0_en = 1'b1; m0_we = 1'b1; m0_addr = 32'h0040; m0_wdata = WD2;
        m1_en = 1'b1; m1_we = 1'b0; m1_addr = 32'h0800;
        tick();
        chk1("t3_owner_a", owner, 1'b0);
        chkw("t3_addr_a", DW'(mem_addr), DW'(32'h0040));
        m0_addr = 32'h0440; m0_we = 1'b0;
        #1;
        chkw("t3_frz_a", DW'(mem_addr), DW'(32'h0040));
        chk1("t3_frz_we", mem_we, 1'b1);
        tick();
        chkw("t3_frz_a2", DW'(mem_addr), DW'(32'h0040));
        mem_ack = 1'b1;
        #1;
        chk1("t3_ack_a", m0_ack, 1'b1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk1("t3_rel_a", busy, 1'b0);
        tick();
        chk1("t3_owner_b", owner, 1'b1);
        chkw("t3_addr_b", DW'(mem_addr), DW'(32'h0800));
        m1_addr = 32'h0900;
        #1;
        chkw("t3_frz_b", DW'(mem_addr), DW'(32'h0800));
        mem_ack = 1'b1;
        #1;
        chk1("t3_ack_b", m1_ack, 1'b1);
        tick();
        mem_ack = 1'b0; m1_en = 1'b0;
        tick();
        chk1("t3_owner_c", owner, 1'b0);
        chkw("t3_addr_c", DW'(mem_addr), DW'(32'h0440));
        chk1("t3_we_c", mem_we, 1'b0);
        mem_ack = 1'b1;
        #1;
        chk1("t3_ack_c", m0_ack, 1'b1);
        tick();
        mem_ack = 1'b0; m0_en = 1'b0;
        tick();

        // watchdog abort, TIMEOUT = 8
        rst = 1'b1; rst_wd = 1'b0;
        tick();
        chk1("t4_err_rst", w_err, 1'b0);
        m0_en = 1'b1; m0_we = 1'b0; m0_addr = 32'h0080;
        tick();
        chk1("t4_en", w_en, 1'b1);
        chk1("t4_busy", w_busy, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            chk1("t4_err_lo", w_err, 1'b0);
            chk1("t4_noack", w_m0_ack, 1'b0);
            tick();
        end
        m0_en = 1'b0;
        #1;
        chk1("t4_last_err", w_err, 1'b0);
        chk1("t4_last_ack", w_m0_ack, 1'b0);
        tick();
        chk1("t4_err", w_err, 1'b1);
        chk1("t4_rel_busy", w_busy, 1'b0);
        chk1("t4_rel_en", w_en, 1'b0);
        chk1("t4_rel_ack", w_m0_ack, 1'b0);
        tick();
        chk1("t4_idle_err", w_err, 1'b1);
        chk1("t4_idle_busy", w_busy, 1'b0);
        m1_en = 1'b1; m1_we = 1'b0; m1_addr = 32'h0C00;
        tick();
        chk1("t4_g1_busy", w_busy, 1'b1);
        chk1("t4_g1_owner", w_owner, 1'b1);
        mem_ack_wd = 1'b1; mem_rdata = RD3;
        #1;
        chk1("t4_g1_ack", w_m1_ack, 1'b1);
        chkw("t4_g1_data", w_m1_data, RD3);
        tick();
        mem_ack_wd = 1'b0; m1_en = 1'b0;
        #1;
        chk1("t4_err_keep", w_err, 1'b1);
        tick();
        chk1("t4_err_keep2", w_err, 1'b1);

        // reset in the middle of a grant
        rst_wd = 1'b1; rst = 1'b0;
        tick();
        m0_en = 1'b1; m0_we = 1'b0; m0_addr = 32'h00C0;
        tick();
        tick();
        tick();
        tick();
        chk1("t5_busy", busy, 1'b1);
        chkw("t5_addr", DW'(mem_addr), DW'(32'h00C0));
        rst = 1'b1; m0_en = 1'b0;
        #1;
        chk1("t5_rst_en", mem_en, 1'b0);
        chk1("t5_rst_busy", busy, 1'b0);
        chk1("t5_rst_owner", owner, 1'b0);
        chk1("t5_rst_err", err, 1'b0);
        chkw("t5_rst_addr", DW'(mem_addr), '0);
        chk1("t5_rst_ack0", m0_ack, 1'b0);
        tick();
        rst = 1'b0; mem_ack = 1'b1;
        #1;
        chk1("t5_late_ack0", m0_ack, 1'b0);
        chk1("t5_late_ack1", m1_ack, 1'b0);
        chk1("t5_late_en", mem_en, 1'b0);
        tick();
        mem_ack = 1'b0;
        chk1("t5_late_busy", busy, 1'b0);
        m0_en = 1'b1; m0_addr = 32'h0100;
        m1_en = 1'b1; m1_addr = 32'h0500;
        tick();
        chk1("t5_en", mem_en, 1'b1);
        chk1("t5_owner", owner, 1'b0);
        chkw("t5_addr2", DW'(mem_addr), DW'(32'h0100));
        mem_ack = 1'b1;
        #1;
        chk1("t5_ack", m0_ack, 1'b1);
        tick();
        mem_ack = 1'b0; m0_en = 1'b0; m1_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
